// File: rtl/oq_regs_rmw_ctrl_pkg.sv
// Shared definitions for the output-queue register-file RMW controller:
// controller state encoding and the address-width helper.
package oq_regs_rmw_ctrl_pkg;

  typedef enum logic [2:0] {
    CLEAR   = 3'd0,
    IDLE    = 3'd1,
    UPD_WB  = 3'd2,
    HOST_RD = 3'd3,
    ACK     = 3'd4
  } rmw_state_t;

  // Minimum 1 so a single-word file still gets a legal address bus.
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/oq_regs_sat_addsub.sv
// Combinational saturating unsigned add/subtract, shared by the register blocks.
// Add clamps to all-ones on carry-out; subtract clamps to zero on borrow.
module oq_regs_sat_addsub #(
  parameter int REG_WIDTH = 32
) (
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  input  logic                 sub,
  output logic [REG_WIDTH-1:0] result,
  output logic                 sat
);

  // Returns {saturated, clamped_result}.
  function automatic logic [REG_WIDTH:0] sat_addsub(
    input logic [REG_WIDTH-1:0] x,
    input logic [REG_WIDTH-1:0] y,
    input logic                 do_sub
  );
    logic [REG_WIDTH:0] ext;
    ext = do_sub ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    if (ext[REG_WIDTH])
      return {1'b1, (do_sub ? {REG_WIDTH{1'b0}} : {REG_WIDTH{1'b1}})};
    return {1'b0, ext[REG_WIDTH-1:0]};
  endfunction

  always_comb begin
    {sat, result} = sat_addsub(a, b, sub);
  end

endmodule

// File: rtl/oq_regs_rmw_ctrl.sv
// Read-modify-write owner of one output-queue register-file RAM port:
// zero-fill after reset, saturating counter updates, host reads/writes.
module oq_regs_rmw_ctrl
  import oq_regs_rmw_ctrl_pkg::*;
#(
  parameter int REG_WIDTH           = 32,
  parameter int NUM_OUTPUT_QUEUES   = 8,
  parameter int REG_FILE_ADDR_WIDTH = log2(NUM_OUTPUT_QUEUES)
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           init_done,

  input  logic                           upd_req,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] upd_queue,
  input  logic                           upd_sub,
  input  logic [REG_WIDTH-1:0]           upd_amount,
  output logic                           upd_ack,
  output logic                           upd_sat,

  input  logic                           reg_req,
  input  logic                           reg_rd_wr_L,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] reg_addr,
  input  logic [REG_WIDTH-1:0]           reg_wr_data,
  output logic                           reg_ack,
  output logic [REG_WIDTH-1:0]           reg_rd_data,

  output logic [REG_FILE_ADDR_WIDTH-1:0] ram_addr,
  output logic                           ram_we,
  output logic [REG_WIDTH-1:0]           ram_din,
  input  logic [REG_WIDTH-1:0]           ram_dout
);

  localparam logic [REG_FILE_ADDR_WIDTH-1:0] LAST_ADDR =
    REG_FILE_ADDR_WIDTH'(NUM_OUTPUT_QUEUES - 1);

  rmw_state_t                     state, state_nxt;
  logic [REG_FILE_ADDR_WIDTH-1:0] clr_cnt;
  logic                           last_host;
  logic                           grant_upd, grant_host;

  logic [REG_FILE_ADDR_WIDTH-1:0] queue_lat;
  logic                           sub_lat;
  logic [REG_WIDTH-1:0]           amt_lat;
  logic [REG_WIDTH-1:0]           wb_data;
  logic                           wb_sat;

  oq_regs_sat_addsub #(
    .REG_WIDTH(REG_WIDTH)
  ) u_addsub (
    .a      (ram_dout),
    .b      (amt_lat),
    .sub    (sub_lat),
    .result (wb_data),
    .sat    (wb_sat)
  );

  always_comb begin
    state_nxt  = state;
    ram_addr   = '0;
    ram_we     = 1'b0;
    ram_din    = '0;
    upd_ack    = 1'b0;
    grant_upd  = 1'b0;
    grant_host = 1'b0;
    case (state)
      CLEAR: begin
        ram_addr = clr_cnt;
        // Held low while reset is asserted so the port is quiet in reset.
        ram_we   = ~reset;
        if (clr_cnt == LAST_ADDR) state_nxt = IDLE;
      end
      IDLE: begin
        // On a tie the requester that did not win last time goes first.
        if (upd_req && (!reg_req || last_host)) grant_upd = 1'b1;
        else if (reg_req)                       grant_host = 1'b1;
        if (grant_upd) begin
          upd_ack   = 1'b1;
          ram_addr  = upd_queue;
          state_nxt = UPD_WB;
        end else if (grant_host) begin
          ram_addr = reg_addr;
          if (reg_rd_wr_L) begin
            state_nxt = HOST_RD;
          end else begin
            ram_we    = 1'b1;
            ram_din   = reg_wr_data;
            state_nxt = ACK;
          end
        end
      end
      UPD_WB: begin
        ram_addr  = queue_lat;
        ram_we    = 1'b1;
        ram_din   = wb_data;
        state_nxt = IDLE;
      end
      HOST_RD: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = CLEAR;
    endcase
  end

  assign upd_sat = (state == UPD_WB) && wb_sat;
  assign reg_ack = (state == ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      init_done   <= 1'b0;
      last_host   <= 1'b1;
      reg_rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) init_done <= 1'b1;
      end
      if (grant_upd)  last_host <= 1'b0;
      if (grant_host) last_host <= 1'b1;
      if (state == HOST_RD) reg_rd_data <= ram_dout;
    end
  end

  // Request capture for the write-back cycle; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (grant_upd) begin
      queue_lat <= upd_queue;
      sub_lat   <= upd_sub;
      amt_lat   <= upd_amount;
    end
  end

endmodule

// File: tb/tb_oq_regs_rmw_ctrl.sv
// Directed bench for oq_regs_rmw_ctrl with a read-before-write dual-port RAM
// model on port A; port B is left idle.
module tb_oq_regs_rmw_ctrl;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          init_done;
  logic          upd_req, upd_sub;
  logic [AW-1:0] upd_queue;
  logic [W-1:0]  upd_amount;
  logic          upd_ack, upd_sat;
  logic          reg_req, reg_rd_wr_L;
  logic [AW-1:0] reg_addr;
  logic [W-1:0]  reg_wr_data;
  logic          reg_ack;
  logic [W-1:0]  reg_rd_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_din;
  logic [W-1:0]  ram_dout;

  logic [W-1:0]  mem [N];
  logic [AW-1:0] addr_b = '0;
  logic          we_b   = 1'b0;
  logic [W-1:0]  din_b  = '0;
  logic [W-1:0]  dout_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < N; i++) mem[i] = 32'hA5A5_A5A5;

  always @(posedge clk) begin
    ram_dout <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_din;
    dout_b <= mem[addr_b];
    if (we_b) mem[addr_b] <= din_b;
  end

  oq_regs_rmw_ctrl #(
    .REG_WIDTH(W), .NUM_OUTPUT_QUEUES(N), .REG_FILE_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .upd_req(upd_req), .upd_queue(upd_queue), .upd_sub(upd_sub),
    .upd_amount(upd_amount), .upd_ack(upd_ack), .upd_sat(upd_sat),
    .reg_req(reg_req), .reg_rd_wr_L(reg_rd_wr_L), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .reg_ack(reg_ack), .reg_rd_data(reg_rd_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  typedef enum int {OP_UPD, OP_WR, OP_RD} op_e;
  typedef struct {
    op_e           op;
    logic [AW-1:0] addr;
    logic          sub;
    logic [W-1:0]  data;
    logic [W-1:0]  exp;   // read data, or expected upd_sat for updates
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: no response within cycle budget", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_upd(input logic [AW-1:0] q, input logic s, input logic [W-1:0] amt,
                        output logic sat);
    int k;
    sat = 1'b0;
    upd_queue = q; upd_sub = s; upd_amount = amt; upd_req = 1'b1;
    k = 0;
    @(negedge clk);
    while (!upd_ack && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!upd_ack) timeout("upd_ack");
    tick();
    upd_req = 1'b0;
    @(negedge clk);
    sat = upd_sat;
    tick();
  endtask

  task automatic host_op(input logic rd, input logic [AW-1:0] a, input logic [W-1:0] d,
                         output logic [W-1:0] q, output int lat);
    reg_rd_wr_L = rd; reg_addr = a; reg_wr_data = d; reg_req = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!reg_ack && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!reg_ack) timeout("reg_ack");
    q = reg_rd_data;
    tick();
    reg_req = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         sat;
    int           lat, k, n;
    int           evs[4];
    logic [W-1:0] evd[4];

    vecs[0]  = '{OP_RD,  3'd5, 1'b0, 32'h0,        32'h0};
    vecs[1]  = '{OP_RD,  3'd3, 1'b0, 32'h0,        32'd15};
    vecs[2]  = '{OP_RD,  3'd4, 1'b0, 32'h0,        32'd2};
    vecs[3]  = '{OP_WR,  3'd2, 1'b0, 32'd4,        32'h0};
    vecs[4]  = '{OP_UPD, 3'd2, 1'b1, 32'd7,        32'd1};
    vecs[5]  = '{OP_RD,  3'd2, 1'b0, 32'h0,        32'h0};
    vecs[6]  = '{OP_WR,  3'd1, 1'b0, 32'hFFFFFFF0, 32'h0};
    vecs[7]  = '{OP_UPD, 3'd1, 1'b0, 32'h20,       32'd1};
    vecs[8]  = '{OP_RD,  3'd1, 1'b0, 32'h0,        32'hFFFFFFFF};
    vecs[9]  = '{OP_WR,  3'd6, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[10] = '{OP_RD,  3'd6, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[11] = '{OP_UPD, 3'd0, 1'b0, 32'hFFFFFFFF, 32'd0};
    vecs[12] = '{OP_RD,  3'd0, 1'b0, 32'h0,        32'hFFFFFFFF};
    vecs[13] = '{OP_UPD, 3'd7, 1'b1, 32'h0,        32'd0};

    reset = 1'b1;
    upd_req = 1'b0; upd_sub = 1'b0; upd_queue = '0; upd_amount = '0;
    reg_req = 1'b0; reg_rd_wr_L = 1'b0; reg_addr = '0; reg_wr_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_init_done", init_done, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_reg_ack", reg_ack, 0);
    chk("rst_upd_ack", upd_ack, 0);
    chk("rst_upd_sat", upd_sat, 0);
    chk("rst_reg_rd_data", reg_rd_data, 0);

    // Zero-fill: one write per cycle to 0..7, init_done after the last
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("clr_addr", ram_addr, i);
      chk("clr_we", ram_we, 1);
      chk("clr_din", ram_din, 0);
      chk("clr_init_done_low", init_done, 0);
      tick();
    end
    @(negedge clk);
    chk("init_done_high", init_done, 1);
    chk("idle_we", ram_we, 0);
    tick();

    // Back-to-back updates to q3: acks at cycles 0 and 2
    upd_queue = 3'd3; upd_sub = 1'b0; upd_amount = 32'd10; upd_req = 1'b1;
    @(negedge clk);
    chk("b2b_ack_c0", upd_ack, 1);
    tick();
    upd_amount = 32'd5;
    @(negedge clk);
    chk("b2b_ack_c1", upd_ack, 0);
    chk("b2b_wb_we", ram_we, 1);
    chk("b2b_wb_addr", ram_addr, 3);
    chk("b2b_wb_din1", ram_din, 10);
    chk("b2b_sat1", upd_sat, 0);
    tick();
    @(negedge clk);
    chk("b2b_ack_c2", upd_ack, 1);
    tick();
    upd_req = 1'b0;
    @(negedge clk);
    chk("b2b_wb_din2", ram_din, 15);
    chk("b2b_sat2", upd_sat, 0);
    tick();

    // Both requesters held: last winner was update, so host, update, host, update
    upd_queue = 3'd4; upd_sub = 1'b0; upd_amount = 32'd1; upd_req = 1'b1;
    reg_rd_wr_L = 1'b1; reg_addr = 3'd4; reg_req = 1'b1;
    n = 0; k = 0;
    while (n < 4 && k < 40) begin
      @(negedge clk);
      if (upd_ack) begin
        evs[n] = 0; evd[n] = '0; n++;
      end else if (reg_ack) begin
        evs[n] = 1; evd[n] = reg_rd_data; n++;
      end
      k++;
    end
    if (n < 4) timeout("fair_grants");
    tick();
    upd_req = 1'b0; reg_req = 1'b0;
    tick();
    if (n == 4) begin
      chk("fair_g0_host", evs[0], 1);
      chk("fair_g1_upd",  evs[1], 0);
      chk("fair_g2_host", evs[2], 1);
      chk("fair_g3_upd",  evs[3], 0);
      chk("fair_rd0", evd[0], 0);
      chk("fair_rd2", evd[2], 1);
    end

    // Table-driven transactions
    for (int i = 0; i < 14; i++) begin
      case (vecs[i].op)
        OP_UPD: begin
          do_upd(vecs[i].addr, vecs[i].sub, vecs[i].data, sat);
          chk($sformatf("vec%0d_upd_sat", i), sat, vecs[i].exp);
        end
        OP_WR: begin
          host_op(1'b0, vecs[i].addr, vecs[i].data, rd, lat);
          chk($sformatf("vec%0d_wr_latency", i), lat, 1);
        end
        default: begin
          host_op(1'b1, vecs[i].addr, '0, rd, lat);
          chk($sformatf("vec%0d_rd_data", i), rd, vecs[i].exp);
          chk($sformatf("vec%0d_rd_latency", i), lat, 2);
        end
      endcase
    end

    // Reset during UPD_WB: pending write dropped, CLEAR restarts at address 0
    upd_queue = 3'd5; upd_sub = 1'b0; upd_amount = 32'd99; upd_req = 1'b1;
    @(negedge clk);
    chk("abort_ack", upd_ack, 1);
    tick();
    upd_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_we_in_reset", ram_we, 0);
    chk("abort_init_done", init_done, 0);
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_clr_addr0", ram_addr, 0);
    chk("abort_clr_we", ram_we, 1);
    k = 0;
    while (!init_done && k < 20) begin
      tick();
      k++;
    end
    if (!init_done) timeout("abort_init_done");
    for (int i = 0; i < N; i++) begin
      host_op(1'b1, AW'(i), '0, rd, lat);
      chk($sformatf("abort_word%0d", i), rd, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
